// File: rtl/qam16_rx_pkg.sv
// Shared constants, state encoding and LFSR helper for the 16-QAM receive BER checker.
package qam16_rx_pkg;

    localparam int unsigned SAMPLE_W = 18;

    // Gray codes per rail, ordered from most negative to most positive level
    localparam logic [1:0] GRAY_NEG_OUTER = 2'b00;
    localparam logic [1:0] GRAY_NEG_INNER = 2'b01;
    localparam logic [1:0] GRAY_POS_INNER = 2'b11;
    localparam logic [1:0] GRAY_POS_OUTER = 2'b10;

    localparam logic signed [SAMPLE_W-1:0] THRESH_DEFAULT = 18'sd43690;

    localparam int unsigned LFSR_LEN = 22;
    localparam int unsigned TAP_HI   = 21;
    localparam int unsigned TAP_LO   = 20;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StCheck  = 2'd1,
        StLocked = 2'd2
    } rx_state_e;

    function automatic logic [LFSR_LEN-1:0] lfsr_next(input logic [LFSR_LEN-1:0] s);
        return {s[LFSR_LEN-2:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/qam16_slicer.sv
// Combinational four-level Gray decision for one rail of a 1s17 sample.
module qam16_slicer
    import qam16_rx_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] THRESH = THRESH_DEFAULT
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic        [1:0]          gray
);

    localparam logic signed [SAMPLE_W-1:0] NEG_THRESH = -THRESH;

    // Exact boundary values fall into the upper bin
    always_comb begin
        if (sample < NEG_THRESH) begin
            gray = GRAY_NEG_OUTER;
        end else if (sample[SAMPLE_W-1]) begin
            gray = GRAY_NEG_INNER;
        end else if (sample < THRESH) begin
            gray = GRAY_POS_INNER;
        end else begin
            gray = GRAY_POS_OUTER;
        end
    end

endmodule

// File: rtl/qam16_rx_ber_checker.sv
// 16-QAM receive slicer plus self-synchronising LFSR reference and windowed symbol-error counter.
module qam16_rx_ber_checker
    import qam16_rx_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] THRESH         = THRESH_DEFAULT,
    parameter int unsigned                VERIFY_LEN     = 64,
    parameter int unsigned                VERIFY_MAX_ERR = 2,
    parameter int unsigned                WIN_LOG2       = 10,
    parameter int unsigned                LOSS_LIMIT     = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sym_clk_en,
    input  logic signed [SAMPLE_W-1:0] rx_i,
    input  logic signed [SAMPLE_W-1:0] rx_q,
    output logic        [3:0]          sym_out,
    output logic                       sym_valid,
    output logic                       locked,
    output logic                       err_flag,
    output logic        [WIN_LOG2:0]   win_err_count,
    output logic                       win_done,
    output logic        [1:0]          state_dbg
);

    localparam int unsigned LOAD_W = $clog2(LFSR_LEN);
    localparam int unsigned CHK_W  = $clog2(VERIFY_LEN);
    localparam int unsigned ERR_W  = $clog2(VERIFY_MAX_ERR + 2);

    localparam logic [LOAD_W-1:0]   LOAD_LAST = LOAD_W'(LFSR_LEN - 1);
    localparam logic [CHK_W-1:0]    CHK_LAST  = CHK_W'(VERIFY_LEN - 1);
    localparam logic [ERR_W-1:0]    ERR_MAX   = ERR_W'(VERIFY_MAX_ERR);
    localparam logic [ERR_W-1:0]    ERR_SAT   = ERR_W'(VERIFY_MAX_ERR + 1);
    localparam logic [WIN_LOG2:0]   WIN_SAT   = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0]   LOSS_LVL  = (WIN_LOG2 + 1)'(LOSS_LIMIT);

    logic [1:0] slice_i;
    logic [1:0] slice_q;

    qam16_slicer #(
        .THRESH (THRESH)
    ) u_slicer_i (
        .sample (rx_i),
        .gray   (slice_i)
    );

    qam16_slicer #(
        .THRESH (THRESH)
    ) u_slicer_q (
        .sample (rx_q),
        .gray   (slice_q)
    );

    logic [3:0]          sym_q;
    logic                sym_valid_q;
    rx_state_e           state_q, state_d;
    logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;
    logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
    logic [CHK_W-1:0]    chk_cnt_q, chk_cnt_d;
    logic [ERR_W-1:0]    chk_err_q, chk_err_d;
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_LOG2:0]   win_acc_q, win_acc_d;
    logic [WIN_LOG2:0]   win_err_q, win_err_d;
    logic                win_done_q, win_done_d;

    logic [LFSR_LEN-1:0] lfsr_adv;
    logic                mismatch;
    logic [ERR_W-1:0]    chk_err_next;
    logic [WIN_LOG2:0]   win_total;

    assign lfsr_adv = lfsr_next(lfsr_q);
    assign mismatch = (sym_q != lfsr_adv[3:0]);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        load_cnt_d   = load_cnt_q;
        chk_cnt_d    = chk_cnt_q;
        chk_err_d    = chk_err_q;
        win_cnt_d    = win_cnt_q;
        win_acc_d    = win_acc_q;
        win_err_d    = win_err_q;
        win_done_d   = 1'b0;
        chk_err_next = chk_err_q;
        win_total    = win_acc_q;

        if (sym_valid_q) begin
            unique case (state_q)
                StSearch: begin
                    // Seed one recovered bit per symbol: bit 0 is the newest LFSR output
                    lfsr_d     = {lfsr_q[LFSR_LEN-2:0], sym_q[0]};
                    load_cnt_d = load_cnt_q + LOAD_W'(1);
                    if (load_cnt_q == LOAD_LAST) begin
                        state_d    = StCheck;
                        load_cnt_d = '0;
                        chk_cnt_d  = '0;
                        chk_err_d  = '0;
                    end
                end
                StCheck: begin
                    lfsr_d = lfsr_adv;
                    if (mismatch && (chk_err_q != ERR_SAT)) begin
                        chk_err_next = chk_err_q + ERR_W'(1);
                    end
                    chk_err_d = chk_err_next;
                    chk_cnt_d = chk_cnt_q + CHK_W'(1);
                    if (chk_err_next > ERR_MAX) begin
                        state_d    = StSearch;
                        load_cnt_d = '0;
                    end else if (chk_cnt_q == CHK_LAST) begin
                        state_d   = StLocked;
                        win_cnt_d = '0;
                        win_acc_d = '0;
                    end
                end
                StLocked: begin
                    lfsr_d    = lfsr_adv;
                    win_cnt_d = win_cnt_q + WIN_LOG2'(1);
                    if (mismatch && (win_acc_q != WIN_SAT)) begin
                        win_total = win_acc_q + (WIN_LOG2 + 1)'(1);
                    end
                    win_acc_d = win_total;
                    // Window closes on this symbol; its own error belongs to the old window
                    if (&win_cnt_q) begin
                        win_err_d  = win_total;
                        win_done_d = 1'b1;
                        win_acc_d  = '0;
                        if (win_total >= LOSS_LVL) begin
                            state_d    = StSearch;
                            load_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = StSearch;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            state_q     <= StSearch;
            lfsr_q      <= '0;
            load_cnt_q  <= '0;
            chk_cnt_q   <= '0;
            chk_err_q   <= '0;
            win_cnt_q   <= '0;
            win_acc_q   <= '0;
            win_err_q   <= '0;
            win_done_q  <= 1'b0;
        end else begin
            if (sym_clk_en) begin
                sym_q <= {slice_i, slice_q};
            end
            sym_valid_q <= sym_clk_en;
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            load_cnt_q  <= load_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            chk_err_q   <= chk_err_d;
            win_cnt_q   <= win_cnt_d;
            win_acc_q   <= win_acc_d;
            win_err_q   <= win_err_d;
            win_done_q  <= win_done_d;
        end
    end

    assign sym_out       = sym_q;
    assign sym_valid     = sym_valid_q;
    assign locked        = (state_q == StLocked);
    assign err_flag      = sym_valid_q && (state_q != StSearch) && mismatch;
    assign win_err_count = win_err_q;
    assign win_done      = win_done_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_qam16_rx_ber_checker.sv
// Randomised self-checking bench for qam16_rx_ber_checker against a transaction-level reference.
module tb_qam16_rx_ber_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        sym_clk_en;
    logic [17:0] rx_i;
    logic [17:0] rx_q;
    logic [3:0]  sym_out;
    logic        sym_valid;
    logic        locked;
    logic        err_flag;
    logic [10:0] win_err_count;
    logic        win_done;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    qam16_rx_ber_checker dut (
        .clk           (clk),
        .reset         (reset),
        .sym_clk_en    (sym_clk_en),
        .rx_i          (rx_i),
        .rx_q          (rx_q),
        .sym_out       (sym_out),
        .sym_valid     (sym_valid),
        .locked        (locked),
        .err_flag      (err_flag),
        .win_err_count (win_err_count),
        .win_done      (win_done),
        .state_dbg     (state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = gathering seed bits, 1 = verifying, 2 = locked
    int          m_mode, m_seed_n, m_vchk, m_verr, m_wn, m_wacc, m_wcount;
    bit          m_wdone;
    logic [21:0] m_lfsr;
    logic [21:0] tx_lfsr;
    int          dut_last_win;
    bit          ever_locked;

    function automatic logic [21:0] ref_step(input logic [21:0] s);
        return {s[20:0], s[21] ^ s[20]};
    endfunction

    function automatic logic [1:0] ref_slice(input int x);
        logic [1:0] gray_of_level [4];
        int lvl;
        gray_of_level = '{2'b00, 2'b01, 2'b11, 2'b10};
        lvl = int'(x >= -43690) + int'(x >= 0) + int'(x >= 43690);
        return gray_of_level[lvl];
    endfunction

    function automatic int ref_level(input logic [1:0] g);
        case (g)
            2'b00:   return -65536;
            2'b01:   return -21845;
            2'b11:   return 21845;
            default: return 65536;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_seed_n = 0; m_vchk = 0; m_verr = 0;
        m_wn = 0; m_wacc = 0; m_wcount = 0; m_wdone = 0;
        m_lfsr = '0;
    endtask

    task automatic model_sym(input logic [3:0] s, output logic exp_err);
        logic [21:0] nxt;
        exp_err = 1'b0;
        m_wdone = 0;
        case (m_mode)
            0: begin
                m_lfsr = {m_lfsr[20:0], s[0]};
                m_seed_n++;
                if (m_seed_n == 22) begin
                    m_mode = 1; m_vchk = 0; m_verr = 0; m_seed_n = 0;
                end
            end
            1: begin
                nxt = ref_step(m_lfsr);
                exp_err = (s != nxt[3:0]);
                m_lfsr = nxt;
                m_vchk++;
                if (exp_err && m_verr < 3) m_verr++;
                if (m_verr > 2) begin
                    m_mode = 0; m_seed_n = 0;
                end else if (m_vchk == 64) begin
                    m_mode = 2; m_wn = 0; m_wacc = 0;
                end
            end
            default: begin
                nxt = ref_step(m_lfsr);
                exp_err = (s != nxt[3:0]);
                m_lfsr = nxt;
                m_wn++;
                if (exp_err && m_wacc < 1024) m_wacc++;
                if (m_wn == 1024) begin
                    m_wcount = m_wacc; m_wdone = 1; m_wn = 0; m_wacc = 0;
                    if (m_wcount >= 256) begin
                        m_mode = 0; m_seed_n = 0;
                    end
                end
            end
        endcase
    endtask

    // Drive at a negedge; check symbol outputs, then FSM outputs after the decision edge
    task automatic send_raw(input int ix, input int iq, input int gap);
        logic [3:0] exp_sym;
        logic       exp_err;
        rx_i = ix[17:0];
        rx_q = iq[17:0];
        sym_clk_en = 1'b1;
        @(negedge clk);
        sym_clk_en = 1'b0;
        exp_sym = {ref_slice(ix), ref_slice(iq)};
        model_sym(exp_sym, exp_err);
        check_eq("sym_valid_hi", sym_valid, 1);
        check_eq("sym_out", sym_out, exp_sym);
        check_eq("err_flag", err_flag, exp_err);
        @(negedge clk);
        check_eq("sym_valid_lo", sym_valid, 0);
        check_eq("state_dbg", state_dbg, m_mode);
        check_eq("locked", locked, m_mode == 2);
        check_eq("win_done", win_done, m_wdone);
        check_eq("win_err_count", win_err_count, m_wcount);
        if (win_done) dut_last_win = int'(win_err_count);
        if (locked) ever_locked = 1;
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic send_sym(input logic [3:0] s, input int gap);
        int ni, nq;
        ni = int'($urandom_range(20000, 0)) - 10000;
        nq = int'($urandom_range(20000, 0)) - 10000;
        send_raw(ref_level(s[3:2]) + ni, ref_level(s[1:0]) + nq, gap);
    endtask

    task automatic tx_sym(output logic [3:0] s);
        tx_lfsr = ref_step(tx_lfsr);
        s = tx_lfsr[3:0];
    endtask

    function automatic int rgap();
        return int'($urandom_range(5, 2));
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        sym_clk_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_sym_out"}, sym_out, 0);
        check_eq({tag, "_sym_valid"}, sym_valid, 0);
        check_eq({tag, "_locked"}, locked, 0);
        check_eq({tag, "_err_flag"}, err_flag, 0);
        check_eq({tag, "_win_err_count"}, win_err_count, 0);
        check_eq({tag, "_win_done"}, win_done, 0);
        check_eq({tag, "_state_dbg"}, state_dbg, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] s;
        int         t1_vals [6];
        logic [1:0] t1_exp  [6];
        int         t3_exp  [3];

        reset = 1'b1;
        sym_clk_en = 1'b0;
        rx_i = '0;
        rx_q = '0;
        dut_last_win = -1;
        ever_locked = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_all_zero("reset");

        // Slicer boundaries on I with Q at zero
        t1_vals = '{-43691, -43690, -1, 0, 43689, 43690};
        t1_exp  = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};
        for (int k = 0; k < 6; k++) begin
            send_raw(t1_vals[k], 0, 3);
            check_eq("t1_slice_i", sym_out[3:2], t1_exp[k]);
            check_eq("t1_slice_q", sym_out[1:0], 2'b11);
        end

        // Clean lock from seed all-ones, strobe every 16 clocks
        do_reset();
        tx_lfsr = 22'h3FFFFF;
        for (int k = 1; k <= 86; k++) begin
            tx_sym(s);
            send_sym(s, 16);
            if (k == 21) check_eq("t2_search_21", state_dbg, 0);
            if (k == 22) check_eq("t2_check_22", state_dbg, 1);
            if (k == 85) check_eq("t2_check_85", state_dbg, 1);
            if (k == 86) check_eq("t2_locked_86", state_dbg, 2);
        end
        dut_last_win = -1;
        for (int k = 0; k < 1024; k++) begin
            tx_sym(s);
            send_sym(s, rgap());
        end
        check_eq("t2_window0", dut_last_win, 0);

        // Five injected errors in the middle window of three
        t3_exp = '{0, 5, 0};
        dut_last_win = -1;
        for (int k = 0; k < 3072; k++) begin
            tx_sym(s);
            if (k == 1100 || k == 1300 || k == 1500 || k == 1700 || k == 1900) s[2] = ~s[2];
            send_sym(s, rgap());
            if (k % 1024 == 1023) begin
                check_eq("t3_window", dut_last_win, t3_exp[k / 1024]);
                dut_last_win = -1;
            end
        end
        check_eq("t3_still_locked", locked, 1);

        // Random data for a full window drops lock, then valid data relocks
        dut_last_win = -1;
        for (int k = 0; k < 1024; k++) begin
            send_sym(4'($urandom_range(15, 0)), rgap());
        end
        check_eq("t4_loss_ge256", dut_last_win >= 256, 1);
        check_eq("t4_unlocked", locked, 0);
        for (int k = 0; k < 86; k++) begin
            tx_sym(s);
            send_sym(s, rgap());
        end
        check_eq("t4_relock", state_dbg, 2);
        check_eq("t4_win_held", win_err_count, m_wcount);

        // Three corrupted symbols early in verify abort the check
        do_reset();
        ever_locked = 0;
        for (int k = 0; k < 22; k++) begin
            tx_sym(s);
            send_sym(s, rgap());
        end
        check_eq("t5_in_check", state_dbg, 1);
        for (int k = 0; k < 10; k++) begin
            tx_sym(s);
            if (k == 2 || k == 5 || k == 8) s[2] = ~s[2];
            send_sym(s, rgap());
            if (k == 7) check_eq("t5_check_after_2err", state_dbg, 1);
            if (k == 8) check_eq("t5_search_on_3rd", state_dbg, 0);
        end
        check_eq("t5_never_locked", ever_locked, 0);

        // Reset while locked with a strobe on the same cycle
        do_reset();
        for (int k = 0; k < 136; k++) begin
            tx_sym(s);
            send_sym(s, rgap());
        end
        check_eq("t6_pre_locked", locked, 1);
        reset = 1'b1;
        sym_clk_en = 1'b1;
        rx_i = 18'sd65536;
        rx_q = 18'sd65536;
        @(negedge clk);
        reset = 1'b0;
        sym_clk_en = 1'b0;
        model_reset();
        check_all_zero("t6_reset");
        for (int k = 1; k <= 86; k++) begin
            tx_sym(s);
            send_sym(s, rgap());
            if (k == 85) check_eq("t6_not_yet", locked, 0);
        end
        check_eq("t6_relock", state_dbg, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
